// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: register-file geometry and write-back requester indices.
package rv32i_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned NREG     = 32;

  localparam int unsigned REQ_ALU  = 0;
  localparam int unsigned REQ_LOAD = 1;
  localparam int unsigned REQ_CSR  = 2;

endpackage

// File: rtl/regfile_wb_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above ptr wins, wrapping to index 0.
module rr_arbiter #(
  parameter int unsigned N  = 3,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] gidx,
  output logic          any
);

  // Two constant-index passes (upper segment, then wrapped segment) avoid a rotated variable index.
  always_comb begin
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!any && req[j] && (j >= 32'(ptr))) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        gidx     = PW'(j);
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!any && req[j] && (j < 32'(ptr))) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        gidx     = PW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: round-robin share of the register-file write port, pending-write
// scoreboard and RAW/WAW stall generation for decode.
module regfile_wb_sched
  import rv32i_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned XLEN  = rv32i_pkg::XLEN,
  parameter int unsigned NREG  = rv32i_pkg::NREG
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*REG_AW-1:0]    req_rd,
  input  logic [N_REQ*XLEN-1:0]      req_data,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       issue_valid,
  input  logic [REG_AW-1:0]          issue_rd,
  input  logic [REG_AW-1:0]          rs1,
  input  logic [REG_AW-1:0]          rs2,
  output logic                       stall,
  output logic                       wr_en,
  output logic [REG_AW-1:0]          wr_addr,
  output logic [XLEN-1:0]            wr_data,
  output logic [NREG-1:0]            busy
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  req_gated;
  logic [N_REQ-1:0]  gnt;
  logic [PW-1:0]     gidx;
  logic              gnt_any;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;
  logic              wr_en_q;
  logic [REG_AW-1:0] wr_addr_q;
  logic [XLEN-1:0]   wr_data_q;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              wr_hit;
  logic              issue_ok;

  assign req_gated = req_valid & {N_REQ{~rst}};

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (req_gated),
    .ptr   (rr_ptr_q),
    .grant (gnt),
    .gidx  (gidx),
    .any   (gnt_any)
  );

  assign req_ready = gnt;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        sel_rd   = req_rd[i*REG_AW +: REG_AW];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any) begin
      rr_ptr_d = (32'(gidx) == N_REQ - 1) ? '0 : gidx + PW'(1);
    end
  end

  // No bypass path: the register being written this cycle is not yet readable by decode.
  assign wr_hit   = wr_en_q && (wr_addr_q != '0) && ((wr_addr_q == rs1) || (wr_addr_q == rs2));
  assign stall    = issue_valid && (busy_q[rs1] || busy_q[rs2] || busy_q[issue_rd] || wr_hit);
  assign issue_ok = issue_valid && !stall && (issue_rd != '0);

  always_comb begin
    busy_d = busy_q;
    if (gnt_any) begin
      busy_d[sel_rd] = 1'b0;
    end
    if (issue_ok) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      busy_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
      wr_en_q  <= gnt_any && (sel_rd != '0);
      if (gnt_any && (sel_rd != '0)) begin
        wr_addr_q <= sel_rd;
        wr_data_q <= sel_data;
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched: directed vector table, hand-written hazard and
// reset sequences, then randomized traffic against a behavioural model.
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd, rs1, rs2;
  logic        stall, wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] busy;

  always #5 clk = ~clk;

  regfile_wb_sched #(.N_REQ(3), .XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1),
    .rs2(rs2), .stall(stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] v, input logic [14:0] rd,
                       input logic [95:0] d, input logic iv, input logic [4:0] ird,
                       input logic [4:0] r1, input logic [4:0] r2);
    rst = r; req_valid = v; req_rd = rd; req_data = d;
    issue_valid = iv; issue_rd = ird; rs1 = r1; rs2 = r2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  v;
    logic [14:0] rd;
    logic [95:0] data;
    logic [2:0]  exp_rdy;
    logic        exp_wen;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  function automatic vec_t mk(logic r, logic [2:0] v, logic [14:0] rd, logic [95:0] d,
                              logic [2:0] er, logic ew, logic [4:0] ea, logic [31:0] ed);
    vec_t x;
    x.rst = r; x.v = v; x.rd = rd; x.data = d;
    x.exp_rdy = er; x.exp_wen = ew; x.exp_addr = ea; x.exp_data = ed;
    return x;
  endfunction

  vec_t tbl[14];

  // Behavioural model state for the random phase.
  int          m_ptr;
  logic [31:0] m_busy;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        pv[3];
  logic [4:0]  prd[3];
  logic [31:0] pdat[3];

  initial begin
    // Reset with every requester asserting: nothing may be granted.
    drive(1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, 1'b0, 5'd0, 5'd0, 5'd0);
    tick();

    tbl[0]  = mk(1, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, 3'b000, 0, 0, 0);
    tbl[1]  = mk(1, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, 3'b000, 0, 0, 0);
    tbl[2]  = mk(0, 3'b001, {5'd0, 5'd0, 5'd5}, {64'h0, 32'hDEADBEEF}, 3'b001, 0, 0, 0);
    tbl[3]  = mk(0, 3'b000, 15'd0, 96'd0, 3'b000, 1, 5'd5, 32'hDEADBEEF);
    tbl[4]  = mk(0, 3'b000, 15'd0, 96'd0, 3'b000, 0, 0, 0);
    tbl[5]  = mk(1, 3'b000, 15'd0, 96'd0, 3'b000, 0, 0, 0);
    tbl[6]  = mk(0, 3'b111, {5'd12, 5'd11, 5'd10}, {32'hA2, 32'hA1, 32'hA0}, 3'b001, 0, 0, 0);
    tbl[7]  = mk(0, 3'b111, {5'd12, 5'd11, 5'd13}, {32'hA2, 32'hA1, 32'hB0}, 3'b010, 1, 5'd10, 32'hA0);
    tbl[8]  = mk(0, 3'b111, {5'd12, 5'd14, 5'd13}, {32'hA2, 32'hB1, 32'hB0}, 3'b100, 1, 5'd11, 32'hA1);
    tbl[9]  = mk(0, 3'b111, {5'd15, 5'd14, 5'd13}, {32'hB2, 32'hB1, 32'hB0}, 3'b001, 1, 5'd12, 32'hA2);
    tbl[10] = mk(0, 3'b000, 15'd0, 96'd0, 3'b000, 1, 5'd13, 32'hB0);
    tbl[11] = mk(0, 3'b000, 15'd0, 96'd0, 3'b000, 0, 0, 0);
    tbl[12] = mk(0, 3'b010, 15'd0, {32'h0, 32'h1234, 32'h0}, 3'b010, 0, 0, 0);
    tbl[13] = mk(0, 3'b000, 15'd0, 96'd0, 3'b000, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].rd, tbl[i].data, 1'b0, 5'd0, 5'd0, 5'd0);
      @(negedge clk);
      chk($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(tbl[i].exp_rdy));
      chk($sformatf("vec%0d wr_en", i), 32'(wr_en), 32'(tbl[i].exp_wen));
      if (tbl[i].exp_wen) begin
        chk($sformatf("vec%0d wr_addr", i), 32'(wr_addr), 32'(tbl[i].exp_addr));
        chk($sformatf("vec%0d wr_data", i), wr_data, tbl[i].exp_data);
      end
      chk($sformatf("vec%0d busy", i), busy, 32'h0);
      chk($sformatf("vec%0d stall", i), 32'(stall), 32'h0);
      tick();
    end

    // RAW/WAW on r7; rr_ptr is 2 here.
    drive(0, 3'b000, 15'd0, 96'd0, 1, 5'd7, 5'd0, 5'd0);
    @(negedge clk); chk("raw issue7 stall", 32'(stall), 0); tick();
    drive(0, 3'b000, 15'd0, 96'd0, 1, 5'd8, 5'd7, 5'd0);
    @(negedge clk); chk("raw busy7", 32'(busy[7]), 1); chk("raw rs1 stall", 32'(stall), 1); tick();
    drive(0, 3'b000, 15'd0, 96'd0, 1, 5'd7, 5'd0, 5'd0);
    @(negedge clk); chk("waw stall", 32'(stall), 1); tick();
    drive(0, 3'b001, {10'd0, 5'd7}, {64'd0, 32'h77}, 1, 5'd8, 5'd7, 5'd0);
    @(negedge clk); chk("raw grant ready", 32'(req_ready), 32'b001);
    chk("raw grant stall", 32'(stall), 1); tick();
    drive(0, 3'b000, 15'd0, 96'd0, 1, 5'd8, 5'd7, 5'd0);
    @(negedge clk); chk("raw wr cycle busy7", 32'(busy[7]), 0);
    chk("raw wr cycle wr_en", 32'(wr_en), 1); chk("raw wr cycle wr_addr", 32'(wr_addr), 7);
    chk("raw window stall", 32'(stall), 1); tick();
    drive(0, 3'b000, 15'd0, 96'd0, 1, 5'd0, 5'd7, 5'd0);
    @(negedge clk); chk("raw released stall", 32'(stall), 0); tick();

    // Reset mid-operation with r3/r9 pending and a load grant in flight; rr_ptr is 1.
    drive(0, 3'b000, 15'd0, 96'd0, 1, 5'd3, 5'd0, 5'd0);
    @(negedge clk); chk("rstmid issue3 stall", 32'(stall), 0); tick();
    drive(0, 3'b010, {5'd0, 5'd4, 5'd0}, {32'h0, 32'h44, 32'h0}, 1, 5'd9, 5'd0, 5'd0);
    @(negedge clk); chk("rstmid load ready", 32'(req_ready), 32'b010); tick();
    drive(1, 3'b000, 15'd0, 96'd0, 0, 5'd0, 5'd0, 5'd0);
    @(negedge clk); chk("rstmid t1 ready", 32'(req_ready), 0);
    chk("rstmid t1 busy", busy, 32'h0000_0208); chk("rstmid t1 wr_en", 32'(wr_en), 1); tick();
    drive(0, 3'b000, 15'd0, 96'd0, 0, 5'd0, 5'd0, 5'd0);
    @(negedge clk); chk("rstmid t2 wr_en", 32'(wr_en), 0); chk("rstmid t2 busy", busy, 0); tick();

    // Clear and set of r6 in one cycle: set wins.
    drive(0, 3'b001, {10'd0, 5'd6}, {64'd0, 32'h66}, 1, 5'd6, 5'd0, 5'd0);
    @(negedge clk); chk("setwin ready", 32'(req_ready), 32'b001); chk("setwin stall", 32'(stall), 0); tick();
    drive(0, 3'b000, 15'd0, 96'd0, 0, 5'd0, 5'd0, 5'd0);
    @(negedge clk); chk("setwin busy6", 32'(busy[6]), 1); chk("setwin wr_addr", 32'(wr_addr), 6); tick();

    // Randomized traffic against the model; the first cycle is a reset to synchronize.
    for (int k = 0; k < 3; k++) begin
      pv[k] = 1'b0; prd[k] = 5'd0; pdat[k] = 32'd0;
    end
    m_ptr = 0; m_busy = 32'd0; m_wen = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        r, iv;
      logic [4:0]  ird, r1, r2;
      logic [2:0]  exp_rdy;
      logic        exp_stall;
      int          g;
      r   = (cyc == 0) || ($urandom % 64 == 0);
      iv  = 1'($urandom % 2);
      ird = 5'($urandom % 8);
      r1  = 5'($urandom % 8);
      r2  = 5'($urandom % 8);
      drive(r, {pv[2], pv[1], pv[0]}, {prd[2], prd[1], prd[0]}, {pdat[2], pdat[1], pdat[0]},
            iv, ird, r1, r2);

      g = -1;
      if (!r) begin
        for (int k = 0; k < 3; k++) begin
          if (g < 0 && pv[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
        end
      end
      exp_rdy = 3'b000;
      if (g >= 0) exp_rdy[g] = 1'b1;
      exp_stall = iv && (m_busy[r1] || m_busy[r2] || m_busy[ird] ||
                         (m_wen && m_waddr != 0 && (m_waddr == r1 || m_waddr == r2)));

      @(negedge clk);
      chk("rand req_ready", 32'(req_ready), 32'(exp_rdy));
      if (cyc > 0) begin
        chk("rand wr_en", 32'(wr_en), 32'(m_wen));
        if (m_wen) begin
          chk("rand wr_addr", 32'(wr_addr), 32'(m_waddr));
          chk("rand wr_data", wr_data, m_wdata);
        end
        chk("rand busy", busy, m_busy);
        if (iv) chk("rand stall", 32'(stall), 32'(exp_stall));
      end

      if (r) begin
        m_ptr = 0; m_busy = 32'd0; m_wen = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
      end else begin
        m_wen = 1'b0;
        if (g >= 0) begin
          m_ptr = (g + 1) % 3;
          m_busy[prd[g]] = 1'b0;
          if (prd[g] != 5'd0) begin
            m_wen = 1'b1; m_waddr = prd[g]; m_wdata = pdat[g];
          end
        end
        if (iv && !exp_stall && ird != 5'd0) m_busy[ird] = 1'b1;
        m_busy[0] = 1'b0;
      end

      for (int k = 0; k < 3; k++) begin
        if (g == k || !pv[k] || ($urandom % 16 == 0)) begin
          pv[k]   = 1'($urandom % 2);
          prd[k]  = 5'($urandom % 8);
          pdat[k] = $urandom;
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
